// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam logic [31:0] CPU_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] CPU_NOP      = 32'h0000_0000;

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register with load enable and synchronous clear to a constant.
module pipe_payload_reg #(
  parameter int             W       = 96,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] payload_q;

  // NOTE: payload is reset as well as the state, because the outputs must
  // show the clear constant (NOP / reset PC / zero data) while empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      payload_q <= CLR_VAL;
    end else if (clear_i) begin
      payload_q <= CLR_VAL;
    end else if (load_i) begin
      payload_q <= d_i;
    end
  end

  assign q_o = payload_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, so in_ready
// comes from the state register only; supports synchronous flush.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LANES     = 2,
  parameter logic [31:0] PC_RESET  = CPU_PC_RESET,
  parameter logic [31:0] NOP_INSTR = CPU_NOP
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [31:0]             in_pc,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy
);

  localparam int DW = LANES * DATA_W;
  localparam int PW = 64 + DW;
  localparam logic [PW-1:0] CLR_PAYLOAD = {NOP_INSTR, PC_RESET, {DW{1'b0}}};

  stage_state_e  state_q, state_d;
  logic          in_fire, out_fire;
  logic          main_load, skid_load;
  logic [PW-1:0] in_payload, main_d, main_q, skid_q;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = {state_q == TWO, state_q == ONE};

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign in_payload = {in_instr, in_pc, in_data};
  // In TWO the main register can only refill from the skid entry.
  assign main_d     = (state_q == TWO) ? skid_q : in_payload;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_payload_reg #(
    .W       (PW),
    .CLR_VAL (CLR_PAYLOAD)
  ) u_main (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .load_i  (main_load),
    .clear_i (flush),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  pipe_payload_reg #(
    .W       (PW),
    .CLR_VAL (CLR_PAYLOAD)
  ) u_skid (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .load_i  (skid_load),
    .clear_i (flush),
    .d_i     (in_payload),
    .q_o     (skid_q)
  );

  assign out_instr = out_valid ? main_q[PW-1 -: 32] : NOP_INSTR;
  assign out_pc    = main_q[DW +: 32];
  assign out_data  = main_q[DW-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboarded checks for pipe_stage_skid (LANES=2, DATA_W=32).
module tb_pipe_stage_skid;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [63:0] out_data;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pipe_stage_skid dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return pc ^ 32'h1300_0013;
  endfunction

  function automatic logic [63:0] mk_data(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_A5A5, pc + 32'd1};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = mk_instr(pc);
    in_data   = mk_data(pc);
    out_ready = rdy;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_empty(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".instr"}, 64'(out_instr), 64'd0);
    check({tag, ".pc"},    64'(out_pc),    64'h3000);
    check({tag, ".data"},  out_data,       64'd0);
    check({tag, ".occ"},   64'(occupancy), 64'd0);
    check({tag, ".rdy"},   64'(in_ready),  64'd1);
  endtask

  task automatic expect_main(input string tag, input logic [31:0] pc, input logic [1:0] occ);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".pc"},    64'(out_pc),    64'(pc));
    check({tag, ".instr"}, 64'(out_instr), 64'(mk_instr(pc)));
    check({tag, ".data"},  out_data,       mk_data(pc));
    check({tag, ".occ"},   64'(occupancy), 64'(occ));
  endtask

  logic [31:0] sb_q[$];
  logic [31:0] next_pc;
  logic [31:0] exp_pc;
  logic        rdy_snap;
  logic        in_f, out_f;

  initial begin
    Reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    expect_empty("in_reset");
    repeat (2) @(posedge CLK);
    #3 Reset = 1'b0;
    tick();
    tick();
    expect_empty("post_reset");

    // Zero-bubble streaming.
    drive(1'b1, 32'h3000, 1'b1);
    tick();
    expect_main("s0", 32'h3000, 2'd1);
    drive(1'b1, 32'h3004, 1'b1);
    tick();
    expect_main("s1", 32'h3004, 2'd1);
    drive(1'b1, 32'h3008, 1'b1);
    tick();
    expect_main("s2", 32'h3008, 2'd1);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("s_drain.valid", 64'(out_valid), 64'd0);
    check("s_drain.instr", 64'(out_instr), 64'd0);

    // Backpressure into the skid entry, then ordered release.
    drive(1'b1, 32'h3000, 1'b0);
    tick();
    expect_main("bp0", 32'h3000, 2'd1);
    check("bp0.rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h3004, 1'b0);
    tick();
    expect_main("bp1", 32'h3000, 2'd2);
    check("bp1.rdy", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h3008, 1'b0);
    tick();
    expect_main("bp_hold", 32'h3000, 2'd2);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    expect_main("pop0", 32'h3004, 2'd1);
    check("pop0.rdy", 64'(in_ready), 64'd1);
    tick();
    check("pop1.valid", 64'(out_valid), 64'd0);
    check("pop1.occ", 64'(occupancy), 64'd0);

    // Flush while full, with an upstream entry offered.
    drive(1'b1, 32'h3000, 1'b0);
    tick();
    drive(1'b1, 32'h3004, 1'b0);
    tick();
    check("fl_full.occ", 64'(occupancy), 64'd2);
    drive(1'b1, 32'h3010, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    expect_empty("flush2");
    tick();
    expect_empty("flush2_after");

    // Flush while ONE: the same-cycle accepted entry is discarded.
    drive(1'b1, 32'h3020, 1'b0);
    tick();
    drive(1'b1, 32'h3014, 1'b1);
    flush = 1'b1;
    check("fl1.rdy", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    expect_empty("flush1");
    tick();
    expect_empty("flush1_after");

    // Asynchronous reset between edges while full.
    drive(1'b1, 32'h3040, 1'b0);
    tick();
    drive(1'b1, 32'h3044, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("ar_full.occ", 64'(occupancy), 64'd2);
    #1 Reset = 1'b1;
    #1;
    expect_empty("async_reset");
    #1 Reset = 1'b0;
    tick();
    expect_empty("after_async_reset");

    // Random valid/ready with a scoreboard.
    next_pc = 32'h4000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(1'($urandom_range(0, 1)), next_pc, 1'($urandom_range(0, 1)));
      #1;
      rdy_snap  = in_ready;
      out_ready = ~out_ready;
      #1;
      if (in_ready !== rdy_snap) check("rnd.rdy_indep", 64'(in_ready), 64'(rdy_snap));
      out_ready = ~out_ready;
      #1;
      if (occupancy == 2'd2 && in_ready !== 1'b0) check("rnd.rdy_full", 64'(in_ready), 64'd0);
      in_f  = in_valid & in_ready;
      out_f = out_valid & out_ready;
      if (out_f) begin
        if (sb_q.size() == 0) begin
          check("rnd.spurious", 64'(out_pc), 64'hFFFF_FFFF);
        end else begin
          exp_pc = sb_q.pop_front();
          check("rnd.pc",    64'(out_pc),    64'(exp_pc));
          check("rnd.instr", 64'(out_instr), 64'(mk_instr(exp_pc)));
          check("rnd.data",  out_data,       mk_data(exp_pc));
        end
      end
      if (in_f) begin
        sb_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      tick();
    end

    // Drain with a bounded cycle budget.
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b0, 32'h0, 1'b1);
      #2;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("drain.spurious", 64'(out_pc), 64'hFFFF_FFFF);
        end else begin
          exp_pc = sb_q.pop_front();
          check("drain.pc", 64'(out_pc), 64'(exp_pc));
        end
      end
      tick();
    end
    check("drain.left", 64'(sb_q.size()), 64'd0);
    check("drain.valid", 64'(out_valid), 64'd0);
    check("rnd.accepted", 64'(next_pc > 32'h4400), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register for the 5-stage CPU.
- Successor to the fixed M/W latch; one instance per stage boundary (F/D, D/E, E/M, M/W).
- Carries instruction word, PC and LANES data words.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure never has a combinational ready path. Also adds synchronous flush and an occupancy output.

Parameters:
- DATA_W, 32, width of each data lane.
- LANES, 2, number of data lanes (M/W: lane0 = ALU result, lane1 = memory read data).
- PC_RESET, 32'h0000_3000, PC value held in main and skid registers after reset or flush.
- NOP_INSTR, 32'h0000_0000, instruction word presented when the output is not valid.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_instr  in  32  upstream instruction.
- in_pc  in  32  upstream PC.
- in_data  in  LANES*DATA_W  upstream lanes; lane k = bits [k*DATA_W +: DATA_W].
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_instr  out  32  main instruction, or NOP_INSTR when out_valid=0.
- out_pc  out  32  main PC.
- out_data  out  LANES*DATA_W  main lanes.
- occupancy  out  2  held entries: 0, 1 or 2.

Behaviour:
- Storage: main register (drives outputs) and skid register, each holding instr, pc and data.
- State: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
- Fire signals: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Handshake outputs:
  - in_ready = (state != TWO), decoded from the state register only. It has no combinational dependency on out_ready, in_valid or flush.
  - out_valid = (state != EMPTY).
  - occupancy = {state==TWO, state==ONE}, giving values 0, 1, 2.
- Transitions (evaluated when flush=0):
  - EMPTY: in_fire -> main <= in, go to ONE. Otherwise stay EMPTY.
  - ONE, in_fire and out_fire: main <= in, stay ONE. Zero-bubble streaming.
  - ONE, in_fire and no out_fire: skid <= in, go to TWO.
  - ONE, out_fire and no in_fire: go to EMPTY.
  - ONE, neither fire: hold.
  - TWO: out_fire -> main <= skid, go to ONE. No in_fire is possible because in_ready=0. Otherwise hold.
- Ordering: entries leave in acceptance order. Nothing is duplicated or dropped except by flush.
- Latency: an entry accepted at edge N is on the outputs after edge N (1 cycle) when the stage was EMPTY, or ONE with out_fire.
- Flush (highest priority after Reset):
  - Next state is EMPTY.
  - Main and skid payloads load instr=NOP_INSTR, pc=PC_RESET, data=0.
  - An input accepted in the same cycle (in_ready=1) is discarded. The upstream handshake still completes.
  - Downstream out_fire in a flush cycle counts as consumed.
- Reset:
  - Asynchronous: state EMPTY; payloads NOP_INSTR / PC_RESET / 0.
  - Outputs during and after reset: out_valid=0, out_instr=NOP_INSTR, out_pc=PC_RESET, out_data=0, occupancy=0, in_ready=1. No capture occurs while Reset=1.
  - Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Output masking:
  - out_instr is NOP_INSTR whenever out_valid=0.
  - out_pc and out_data hold their last main-register contents. Downstream must qualify them with out_valid.
- Stability: while out_valid=1 and out_ready=0, all out_* are stable.
- Widths: no arithmetic; LANES=1 and DATA_W=8 must elaborate.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - state enum {EMPTY, ONE, TWO};
  - CPU_PC_RESET = 32'h0000_3000;
  - CPU_NOP = 32'h0000_0000.
- One natural sub-module, pipe_payload_reg: a parametrised payload register with load enable and clear-to-constant, instantiated twice (main, skid).
- State logic stays in pipe_stage_skid.

Test Plan:
- Reset release, idle inputs -> out_valid=0, out_pc=32'h3000, out_instr=0, in_ready=1, occupancy=0.
- Stream PCs 0x3000, 0x3004, 0x3008 on consecutive cycles with out_ready=1 -> outputs appear 1 cycle later, back-to-back, occupancy stays 1.
- Accept 0x3000, then 0x3004 with out_ready=0 -> occupancy=2, in_ready=0, out_pc stays 0x3000. Raise out_ready -> 0x3000 then 0x3004 in order, in_ready=1 one cycle after the first pop.
- occupancy=2, assert flush with in_valid=1 (PC 0x3010) -> next cycle occupancy=0, out_valid=0, out_instr=0, out_pc=0x3000; 0x3010 never appears at the output.
- Assert Reset asynchronously between edges with occupancy=2 -> out_valid falls before the next CLK edge; all outputs at reset values.
- Random valid/ready for 10k cycles, LANES=2 with lane data = {pc^0xA5A5A5A5, pc+1} -> scoreboard: in-order, lossless, in_ready never depends on out_ready in the same cycle.
